// File: rtl/btn_intr_pkg.sv
// Shared state encoding and default sizing for the button-event interrupt block.
package btn_intr_pkg;

   typedef enum logic [1:0] {
      ST_idle    = 2'd0,
      ST_intr    = 2'd1,
      ST_holdoff = 2'd2
   } INTR_STATES;

   localparam int PEND_WIDTH_DEF   = 4;
   localparam int HOLDOFF_CLKS_DEF = 8;

endpackage

// File: rtl/up_down_sat_counter.sv
// Up/down counter that saturates at all-ones; SAT_OVF flags an increment lost at max.
// Single-cycle update; simultaneous INC and DEC cancel and never report overflow.
module up_down_sat_counter
   import btn_intr_pkg::*;
#(
   parameter int WIDTH = PEND_WIDTH_DEF
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             INC,
   input  logic             DEC,
   output logic [WIDTH-1:0] COUNT,
   output logic             SAT_OVF
);

   localparam logic [WIDTH-1:0] CNT_MAX = '1;

   logic [WIDTH-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      SAT_OVF = 1'b0;
      if (INC && !DEC) begin
         if (count_q == CNT_MAX) SAT_OVF = 1'b1;
         else                    count_d = count_q + 1'b1;
      end else if (DEC && !INC) begin
         // DEC is only raised while an interrupt is outstanding, so count_q >= 1
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) count_q <= '0;
      else     count_q <= count_d;
   end

   assign COUNT = count_q;

endmodule

// File: rtl/btn_event_intr.sv
// Turns debounced button pulses into a level interrupt with ack handshake, pending count and holdoff.
// INTR rises 1 clock after the first EVENT-high edge; after an ack it stays low HOLDOFF_CLKS+1 cycles.
module btn_event_intr
   import btn_intr_pkg::*;
#(
   parameter int PEND_WIDTH   = PEND_WIDTH_DEF,
   parameter int HOLDOFF_CLKS = HOLDOFF_CLKS_DEF
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  EVENT,
   input  logic                  INTR_ACK,
   input  logic                  CLR_OVF,
   output logic                  INTR,
   output logic [PEND_WIDTH-1:0] PEND_CNT,
   output logic                  OVERFLOW
);

   localparam logic [7:0] HOLD_LAST = 8'(HOLDOFF_CLKS - 1);

   INTR_STATES state_q, state_d;
   logic [7:0] hold_cnt_q, hold_cnt_d;
   logic       evt_q;
   logic       ovf_q, ovf_d;
   logic       evt_rise, ack_dec, sat_ovf;

   assign evt_rise = EVENT & ~evt_q;
   assign ack_dec  = (state_q == ST_intr) & INTR_ACK;

   up_down_sat_counter #(.WIDTH(PEND_WIDTH)) u_pend (
      .CLK     (CLK),
      .RST     (RST),
      .INC     (evt_rise),
      .DEC     (ack_dec),
      .COUNT   (PEND_CNT),
      .SAT_OVF (sat_ovf)
   );

   always_comb begin
      state_d    = state_q;
      hold_cnt_d = hold_cnt_q;
      case (state_q)
         ST_idle: begin
            if ((PEND_CNT != '0) || evt_rise) state_d = ST_intr;
         end
         ST_intr: begin
            if (INTR_ACK) begin
               state_d    = ST_holdoff;
               hold_cnt_d = 8'd0;
            end
         end
         ST_holdoff: begin
            // Ack is deliberately ignored here so a held ack costs only one event
            hold_cnt_d = hold_cnt_q + 8'd1;
            if (hold_cnt_q == HOLD_LAST) state_d = ST_idle;
         end
         default: state_d = ST_idle;
      endcase
   end

   always_comb begin
      ovf_d = ovf_q;
      if (sat_ovf)      ovf_d = 1'b1;
      else if (CLR_OVF) ovf_d = 1'b0;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q    <= ST_idle;
         hold_cnt_q <= 8'd0;
         evt_q      <= 1'b0;
         ovf_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         hold_cnt_q <= hold_cnt_d;
         evt_q      <= EVENT;
         ovf_q      <= ovf_d;
      end
   end

   assign INTR     = (state_q == ST_intr);
   assign OVERFLOW = ovf_q;

endmodule

// File: tb/tb_btn_event_intr.sv
// Directed bench for btn_event_intr: a vector table for the basic handshake plus hand-written corner sequences.
module tb_btn_event_intr;

   logic       clk = 1'b0;
   logic       rst, ev, ack, clr;
   logic       intr, ovf;
   logic [3:0] pend;

   int n_total = 0;
   int n_pass  = 0;

   btn_event_intr #(.PEND_WIDTH(4), .HOLDOFF_CLKS(8)) dut (
      .CLK      (clk),
      .RST      (rst),
      .EVENT    (ev),
      .INTR_ACK (ack),
      .CLR_OVF  (clr),
      .INTR     (intr),
      .PEND_CNT (pend),
      .OVERFLOW (ovf)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       rst, ev, ack, clr;
      logic       intr;
      logic [3:0] pend;
      logic       ovf;
   } vec_t;

   vec_t tbl[14];

   task automatic chk(input string nm, input int act, input int exp);
      n_total++;
      if (act !== exp) $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      else             n_pass++;
   endtask

   task automatic drive(input logic r, input logic e, input logic a, input logic c);
      rst = r; ev = e; ack = a; clr = c;
   endtask

   // one clock edge, outputs settled and sampled 1 time unit later
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse(input int hi, input int lo);
      for (int i = 0; i < hi; i++) begin drive(0, 1, 0, 0); step(); end
      for (int i = 0; i < lo; i++) begin drive(0, 0, 0, 0); step(); end
   endtask

   task automatic do_reset();
      drive(1, 0, 0, 0); step();
      drive(0, 0, 0, 0);
   endtask

   initial begin
      int lowcnt;

      // reset, 3-cycle pulse, single ack, then quiet
      tbl[0]  = '{rst:1, ev:0, ack:0, clr:0, intr:0, pend:0, ovf:0};
      tbl[1]  = '{rst:0, ev:1, ack:0, clr:0, intr:1, pend:1, ovf:0};
      tbl[2]  = '{rst:0, ev:1, ack:0, clr:0, intr:1, pend:1, ovf:0};
      tbl[3]  = '{rst:0, ev:1, ack:0, clr:0, intr:1, pend:1, ovf:0};
      tbl[4]  = '{rst:0, ev:0, ack:1, clr:0, intr:0, pend:0, ovf:0};
      for (int i = 5; i < 14; i++)
         tbl[i] = '{rst:0, ev:0, ack:0, clr:0, intr:0, pend:0, ovf:0};

      drive(0, 0, 0, 0);
      step();
      for (int i = 0; i < 14; i++) begin
         drive(tbl[i].rst, tbl[i].ev, tbl[i].ack, tbl[i].clr);
         step();
         chk($sformatf("vec%0d_intr", i), intr, tbl[i].intr);
         chk($sformatf("vec%0d_pend", i), pend, tbl[i].pend);
         chk($sformatf("vec%0d_ovf",  i), ovf,  tbl[i].ovf);
      end
      repeat (20) step();
      chk("quiet_intr", intr, 0);

      // three pulses, no ack, then three acks with 9-cycle low gaps
      do_reset();
      for (int p = 0; p < 3; p++) pulse(3, 5);
      chk("three_pend", pend, 3);
      chk("three_intr", intr, 1);
      for (int k = 0; k < 3; k++) begin
         lowcnt = 0;
         while (intr !== 1'b1 && lowcnt < 50) begin drive(0, 0, 0, 0); step(); lowcnt++; end
         chk($sformatf("ack%0d_intr_ready", k), intr, 1);
         drive(0, 0, 1, 0); step();
         chk($sformatf("ack%0d_pend", k), pend, 2 - k);
         chk($sformatf("ack%0d_intr_low", k), intr, 0);
         drive(0, 0, 0, 0);
         if (k < 2) begin
            lowcnt = 1;
            step();
            while (intr !== 1'b1 && lowcnt < 50) begin step(); lowcnt++; end
            chk($sformatf("gap%0d_low_cycles", k), lowcnt, 9);
         end
      end
      repeat (20) step();
      chk("after_acks_intr", intr, 0);
      chk("after_acks_pend", pend, 0);

      // long EVENT counts once
      do_reset();
      pulse(100, 1);
      chk("long_pend", pend, 1);
      chk("long_intr", intr, 1);

      // saturation and sticky overflow
      do_reset();
      for (int p = 0; p < 15; p++) pulse(1, 1);
      chk("sat15_pend", pend, 15);
      chk("sat15_ovf", ovf, 0);
      pulse(1, 1);
      chk("sat16_pend", pend, 15);
      chk("sat16_ovf", ovf, 1);
      pulse(1, 1);
      chk("sat17_pend", pend, 15);
      drive(0, 0, 0, 1); step();
      chk("clr_ovf", ovf, 0);
      chk("clr_pend", pend, 15);

      // rise coinciding with an accepted ack at max: no change, no overflow
      drive(0, 1, 1, 0); step();
      chk("coinc_pend", pend, 15);
      chk("coinc_ovf", ovf, 0);
      chk("coinc_intr", intr, 0);
      for (int i = 0; i < 8; i++) begin drive(0, 1, 1, 0); step(); end
      chk("held_ack_holdoff_pend", pend, 15);
      drive(0, 0, 0, 0); step();
      chk("reassert_intr", intr, 1);
      for (int i = 0; i < 10; i++) begin drive(0, 0, 1, 0); step(); end
      chk("held_ack_pend", pend, 14);
      chk("held_ack_intr", intr, 1);
      drive(0, 0, 0, 0); step();

      // reset during holdoff with 5 pending
      do_reset();
      for (int p = 0; p < 6; p++) pulse(1, 1);
      drive(0, 0, 1, 0); step();
      drive(0, 0, 0, 0); step(); step();
      chk("holdoff_pend", pend, 5);
      chk("holdoff_intr", intr, 0);
      drive(1, 0, 0, 0); step();
      chk("rst_pend", pend, 0);
      chk("rst_intr", intr, 0);
      chk("rst_ovf", ovf, 0);
      drive(0, 0, 0, 0); step();
      chk("rst_quiet_intr", intr, 0);
      drive(0, 1, 0, 0); step();
      chk("post_rst_intr", intr, 1);
      chk("post_rst_pend", pend, 1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/btn_event_intr.md
Name: btn_event_intr

Overview:
- Consumer end of the debounced-button path: takes the one-shot pulse from the button debouncer and delivers it to the OTTER CPU as a level interrupt with an acknowledge handshake.
- Counts button events that arrive while an interrupt is outstanding, so no press is lost.
- Enforces a minimum low gap between successive interrupts.
- Sits between the debouncer output and the OTTER interrupt input / MMIO status register.

Parameters:
- PEND_WIDTH, 4, width of the pending-event counter (max 2^PEND_WIDTH-1 = 15 pending).
- HOLDOFF_CLKS, 8, CLK cycles INTR is held low after an accepted ack before it may re-assert (range 1..255).

Ports:
- CLK  input  1  50 MHz OTTER clock; all logic on posedge.
- RST  input  1  synchronous, active-high reset.
- EVENT  input  1  one-shot pulse from the debouncer (multi-cycle high allowed).
- INTR_ACK  input  1  CPU acknowledge; only honoured while INTR=1.
- CLR_OVF  input  1  clears sticky OVERFLOW.
- INTR  output  1  interrupt request, level.
- PEND_CNT  output  PEND_WIDTH  events captured but not yet acknowledged.
- OVERFLOW  output  1  sticky; an event was dropped at saturation.

Behaviour:
- Reset (RST=1 at a posedge): state ST_idle, evt_q=0, PEND_CNT=0, holdoff count=0, OVERFLOW=0. INTR=0 from the next cycle. Reset mid-interrupt or mid-holdoff abandons all pending events.
- Edge detect:
  - evt_q <= EVENT each clock.
  - evt_rise = EVENT & ~evt_q.
  - Exactly one event per low-to-high transition; EVENT held high for any length counts once.
- Pending counter, updated at each posedge:
  - inc = evt_rise; dec = (PS==ST_intr) & INTR_ACK.
  - inc & ~dec: +1 if below max. At max, hold and set OVERFLOW=1.
  - dec & ~inc: -1. dec only occurs in ST_intr, where PEND_CNT >= 1, so there is no underflow.
  - inc & dec: unchanged. No overflow, even at max.
- OVERFLOW: cleared by CLR_OVF unless a new overflow occurs in the same cycle; set wins.
- FSM states and transitions (INTR is a Moore decode: 1 only in ST_intr):
  - ST_idle: if PEND_CNT!=0 or evt_rise -> ST_intr; else stay.
  - ST_intr: if INTR_ACK -> ST_holdoff and clear the holdoff count; else stay.
  - ST_holdoff: count up each cycle. When count==HOLDOFF_CLKS-1 -> ST_idle; else stay. INTR_ACK is ignored here.
  - default / illegal encoding: -> ST_idle.
- Latency:
  - EVENT first sampled high at edge k gives INTR=1 in the cycle after edge k (1 clock).
  - Ack sampled at edge a gives INTR=0 after edge a.
  - With events still pending, INTR re-asserts after edge a+HOLDOFF_CLKS+1, i.e. HOLDOFF_CLKS+1 low cycles.
- INTR_ACK held high continuously: at most one decrement per interrupt, because ST_holdoff ignores ack.
- Events arriving during ST_intr or ST_holdoff only increment PEND_CNT.
- Holdoff counter width is 8 bits.

Decomposition:
- Package btn_intr_pkg holds:
  - typedef enum {ST_idle, ST_intr, ST_holdoff} INTR_STATES;
  - default constants for PEND_WIDTH and HOLDOFF_CLKS.
- Sub-module up_down_sat_counter (parameter WIDTH; inputs CLK, RST, INC, DEC; outputs COUNT, SAT_OVF) implements the pending counter.
- The FSM, edge detect and holdoff counter stay in the top module.

Test Plan:
- Reset, then a single 3-cycle EVENT pulse -> INTR=1 one cycle after the first EVENT-high edge; PEND_CNT=1. Ack for 1 cycle -> INTR=0, PEND_CNT=0. INTR stays 0 indefinitely.
- Three EVENT pulses (3 high / 5 low each) with no ack -> PEND_CNT=3, INTR stays high. Three acks, each issued when INTR=1 -> INTR low for exactly 9 cycles (HOLDOFF_CLKS=8) between assertions; PEND_CNT steps 2, 1, 0.
- EVENT held high for 100 cycles -> PEND_CNT=1 only.
- 17 pulses with no ack -> PEND_CNT saturates at 15 and OVERFLOW=1 on the 16th rise. CLR_OVF pulse -> OVERFLOW=0; PEND_CNT stays 15.
- evt_rise in the same cycle as an accepted ack with PEND_CNT=15 -> PEND_CNT stays 15, OVERFLOW stays 0. INTR_ACK held high through holdoff -> only one decrement.
- RST asserted in ST_holdoff with PEND_CNT=5 -> next cycle PEND_CNT=0, INTR=0, OVERFLOW=0. A subsequent EVENT -> normal 1-cycle INTR latency.
